// File: rtl/mult_stage_pipe_pkg.sv
// Shared PE datapath types for the multiply stage: operation modes, default widths and lane record.
package mult_stage_pipe_pkg;

  typedef enum logic [1:0] {
    MS_MAC    = 2'd0,
    MS_MUL    = 2'd1,
    MS_BYPASS = 2'd2
  } ms_mode_e;

  localparam int unsigned MS_DWD   = 8;
  localparam int unsigned MS_PSW   = 20;
  localparam int unsigned MS_SIDEW = 8;

  typedef struct packed {
    logic [MS_DWD-1:0] inp;
    logic [MS_DWD-1:0] weight;
    logic [MS_PSW-1:0] psum;
  } ms_lane_t;

  // Mode 3 is reserved and behaves as BYPASS, so only MAC/MUL do arithmetic.
  function automatic logic is_arith(logic [1:0] mode);
    return (mode == MS_MAC) || (mode == MS_MUL);
  endfunction

endpackage

// File: rtl/ms_lane_alu.sv
// Per-row combinational datapath: multiplier (front of the pipe) and accumulate/saturate (back).
module ms_lane_alu
  import mult_stage_pipe_pkg::*;
#(
  parameter int unsigned DWD = MS_DWD,
  parameter int unsigned PSW = MS_PSW,
  parameter int unsigned SAT = 1
) (
  input  logic [DWD-1:0]   in_i,
  input  logic [DWD-1:0]   w_i,
  input  logic             mul_signed_i,
  output logic [2*DWD-1:0] mul_prod_o,
  input  logic [2*DWD-1:0] prod_i,
  input  logic [PSW-1:0]   psum_i,
  input  logic [1:0]       mode_i,
  input  logic             signed_i,
  input  logic             lane_en_i,
  output logic [PSW-1:0]   psum_o,
  output logic [2*DWD-1:0] prod_o,
  output logic             ovf_o
);

  localparam int unsigned PW = 2 * DWD;
  localparam int unsigned SW = PSW + 2;

  logic [PW-1:0]  a_ext, b_ext;
  logic [SW-1:0]  prod_ext, psum_ext, sum;
  logic [2:0]     top;
  logic           arith, ovf;
  logic [PSW-1:0] sat_val;

  // Extending both operands to the full product width keeps the low bits exact for either sign.
  assign a_ext      = {{DWD{mul_signed_i & in_i[DWD-1]}}, in_i};
  assign b_ext      = {{DWD{mul_signed_i & w_i[DWD-1]}}, w_i};
  assign mul_prod_o = a_ext * b_ext;

  assign arith    = is_arith(mode_i);
  assign prod_ext = {{(SW-PW){signed_i & prod_i[PW-1]}}, prod_i};
  assign psum_ext = {{2{signed_i & psum_i[PSW-1]}}, psum_i};

  always_comb begin
    sum = psum_ext;
    case (ms_mode_e'(mode_i))
      MS_MAC:  sum = prod_ext + psum_ext;
      MS_MUL:  sum = prod_ext;
      default: sum = psum_ext;
    endcase
  end

  // Signed result fits iff the bits from the PSW sign position upward all agree.
  assign top = sum[SW-1:PSW-1];
  assign ovf = arith & (signed_i ? ~((&top) | ~(|top)) : (|sum[SW-1:PSW]));

  assign sat_val = signed_i ? (sum[SW-1] ? {1'b1, {(PSW-1){1'b0}}} : {1'b0, {(PSW-1){1'b1}}})
                            : {PSW{1'b1}};

  always_comb begin
    psum_o = '0;
    if (lane_en_i) psum_o = (ovf && (SAT != 0)) ? sat_val : sum[PSW-1:0];
  end

  assign prod_o = (lane_en_i & arith) ? prod_i : '0;
  assign ovf_o  = lane_en_i & ovf;

endmodule

// File: rtl/mult_stage_pipe.sv
// Multiply stage between fetch and sum stages: elastic NSTAGE-deep pipeline, product in the first
// register stage, accumulate/saturate into the last one, sideband carried alongside.
module mult_stage_pipe
  import mult_stage_pipe_pkg::*;
#(
  parameter int unsigned DWD    = MS_DWD,
  parameter int unsigned PEROW  = 4,
  parameter int unsigned NSTAGE = 2,
  parameter int unsigned PSW    = MS_PSW,
  parameter int unsigned SIDEW  = MS_SIDEW,
  parameter int unsigned SAT    = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   src_rdy,
  output logic                   src_ack,
  input  logic [1:0]             i_mode,
  input  logic                   i_signed,
  input  logic [PEROW-1:0]       i_lane_en,
  input  logic [PEROW*DWD-1:0]   i_input,
  input  logic [PEROW*DWD-1:0]   i_weight,
  input  logic [PEROW*PSW-1:0]   i_psum,
  input  logic [SIDEW-1:0]       i_side,
  output logic                   dst_rdy,
  input  logic                   dst_ack,
  output logic [PEROW*PSW-1:0]   o_psum,
  output logic [PEROW*2*DWD-1:0] o_prod,
  output logic [PEROW-1:0]       o_ovf,
  output logic [SIDEW-1:0]       o_side,
  output logic                   o_busy
);

  localparam int unsigned MidN = (NSTAGE > 1) ? NSTAGE - 1 : 1;

  typedef struct packed {
    logic [PEROW*2*DWD-1:0] prod;
    logic [PEROW*PSW-1:0]   psum;
    logic [1:0]             mode;
    logic                   sgn;
    logic [PEROW-1:0]       lane_en;
    logic [SIDEW-1:0]       side;
  } front_t;

  logic [NSTAGE-1:0] v_q, adv, ld, in_v;
  logic [NSTAGE:0]   v_chain;
  logic              room;

  front_t                 s0_d, fin_src;
  front_t [MidN-1:0]      mid_q, mid_d;
  logic [PEROW*2*DWD-1:0] mul_prod, fin_prod, prod_q;
  logic [PEROW*PSW-1:0]   fin_psum, psum_q;
  logic [PEROW-1:0]       fin_ovf, ovf_q;
  logic [SIDEW-1:0]       side_q;

  // Walk from the output backwards: a stage moves if the one after it is empty or moving.
  always_comb begin
    adv  = '0;
    room = dst_ack;
    for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
      adv[k] = v_q[k] & room;
      room   = ~v_q[k] | room;
    end
    src_ack = room;
  end

  assign v_chain = {v_q, src_rdy};
  assign in_v    = v_chain[NSTAGE-1:0];
  assign ld      = ~v_q | adv;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) v_q <= '0;
    else       v_q <= (v_q & ~ld) | (in_v & ld);
  end

  always_comb begin
    s0_d.prod    = mul_prod;
    s0_d.psum    = i_psum;
    s0_d.mode    = i_mode;
    s0_d.sgn     = i_signed;
    s0_d.lane_en = i_lane_en;
    s0_d.side    = i_side;
  end

  always_comb begin
    mid_d[0] = s0_d;
    for (int k = 1; k < int'(MidN); k++) mid_d[k] = mid_q[k-1];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mid_q <= '0;
    end else begin
      for (int k = 0; k < int'(MidN); k++) begin
        if ((NSTAGE > 1) && ld[k] && in_v[k]) mid_q[k] <= mid_d[k];
      end
    end
  end

  // With a single stage the product feeds the accumulator in the same cycle.
  assign fin_src = (NSTAGE == 1) ? s0_d : mid_q[MidN-1];

  for (genvar r = 0; r < PEROW; r++) begin : g_lane
    ms_lane_alu #(
      .DWD(DWD),
      .PSW(PSW),
      .SAT(SAT)
    ) u_alu (
      .in_i        (i_input[r*DWD +: DWD]),
      .w_i         (i_weight[r*DWD +: DWD]),
      .mul_signed_i(i_signed),
      .mul_prod_o  (mul_prod[r*2*DWD +: 2*DWD]),
      .prod_i      (fin_src.prod[r*2*DWD +: 2*DWD]),
      .psum_i      (fin_src.psum[r*PSW +: PSW]),
      .mode_i      (fin_src.mode),
      .signed_i    (fin_src.sgn),
      .lane_en_i   (fin_src.lane_en[r]),
      .psum_o      (fin_psum[r*PSW +: PSW]),
      .prod_o      (fin_prod[r*2*DWD +: 2*DWD]),
      .ovf_o       (fin_ovf[r])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      psum_q <= '0;
      prod_q <= '0;
      ovf_q  <= '0;
      side_q <= '0;
    end else if (ld[NSTAGE-1] && in_v[NSTAGE-1]) begin
      psum_q <= fin_psum;
      prod_q <= fin_prod;
      ovf_q  <= fin_ovf;
      side_q <= fin_src.side;
    end
  end

  assign dst_rdy = v_q[NSTAGE-1];
  assign o_busy  = |v_q;
  assign o_psum  = psum_q;
  assign o_prod  = prod_q;
  assign o_ovf   = ovf_q;
  assign o_side  = side_q;

endmodule

// File: tb/tb_mult_stage_pipe.sv
// Bench for mult_stage_pipe: directed corner cases plus random streams against an integer model.
module tb_mult_stage_pipe;
  import mult_stage_pipe_pkg::*;

  localparam int unsigned DWD    = 8;
  localparam int unsigned PEROW  = 4;
  localparam int unsigned NSTAGE = 2;
  localparam int unsigned PSW    = 20;
  localparam int unsigned SIDEW  = 8;

  logic        i_clk = 1'b0;
  logic        i_rst, src_rdy, dst_ack, i_signed;
  logic [1:0]  i_mode;
  logic [3:0]  i_lane_en;
  logic [31:0] i_input, i_weight;
  logic [79:0] i_psum;
  logic [7:0]  i_side;

  logic        src_ack, dst_rdy, o_busy;
  logic [79:0] o_psum;
  logic [63:0] o_prod;
  logic [3:0]  o_ovf;
  logic [7:0]  o_side;

  logic        src_ack_w, dst_rdy_w, o_busy_w;
  logic [79:0] o_psum_w;
  logic [63:0] o_prod_w;
  logic [3:0]  o_ovf_w;
  logic [7:0]  o_side_w;

  mult_stage_pipe #(
    .DWD(DWD), .PEROW(PEROW), .NSTAGE(NSTAGE), .PSW(PSW), .SIDEW(SIDEW), .SAT(1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .src_rdy(src_rdy), .src_ack(src_ack), .i_mode(i_mode),
    .i_signed(i_signed), .i_lane_en(i_lane_en), .i_input(i_input), .i_weight(i_weight),
    .i_psum(i_psum), .i_side(i_side), .dst_rdy(dst_rdy), .dst_ack(dst_ack), .o_psum(o_psum),
    .o_prod(o_prod), .o_ovf(o_ovf), .o_side(o_side), .o_busy(o_busy)
  );

  mult_stage_pipe #(
    .DWD(DWD), .PEROW(PEROW), .NSTAGE(NSTAGE), .PSW(PSW), .SIDEW(SIDEW), .SAT(0)
  ) dut_w (
    .i_clk(i_clk), .i_rst(i_rst), .src_rdy(src_rdy), .src_ack(src_ack_w), .i_mode(i_mode),
    .i_signed(i_signed), .i_lane_en(i_lane_en), .i_input(i_input), .i_weight(i_weight),
    .i_psum(i_psum), .i_side(i_side), .dst_rdy(dst_rdy_w), .dst_ack(dst_ack), .o_psum(o_psum_w),
    .o_prod(o_prod_w), .o_ovf(o_ovf_w), .o_side(o_side_w), .o_busy(o_busy_w)
  );

  initial forever #5 i_clk = ~i_clk;

  typedef struct {
    logic [79:0] psum_s;
    logic [79:0] psum_w;
    logic [63:0] prod;
    logic [63:0] pmask;
    logic [3:0]  ovf;
    logic [7:0]  side;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Integer reference: full-precision result, then range check, clamp or wrap.
  function automatic exp_t model(input logic [1:0] m, input logic s, input logic [3:0] le,
                                 input logic [31:0] inv, input logic [31:0] wv,
                                 input logic [79:0] pv, input logic [7:0] sd);
    exp_t e;
    e.psum_s = '0; e.psum_w = '0; e.prod = '0; e.pmask = '0; e.ovf = '0; e.side = sd;
    for (int r = 0; r < 4; r++) begin
      ms_lane_t ln;
      longint a, b, p, pp, res, lo, hi, sres;
      bit arith, ov;
      ln.inp = inv[r*8 +: 8]; ln.weight = wv[r*8 +: 8]; ln.psum = pv[r*20 +: 20];
      a  = s ? longint'($signed(ln.inp))    : longint'(ln.inp);
      b  = s ? longint'($signed(ln.weight)) : longint'(ln.weight);
      pp = s ? longint'($signed(ln.psum))   : longint'(ln.psum);
      p  = a * b;
      arith = (m == 2'd0) || (m == 2'd1);
      res = (m == 2'd0) ? p + pp : (m == 2'd1) ? p : pp;
      lo  = s ? -(longint'(1) << 19) : 0;
      hi  = s ? (longint'(1) << 19) - 1 : (longint'(1) << 20) - 1;
      ov  = arith && (res < lo || res > hi);
      sres = ov ? ((res < lo) ? lo : hi) : res;
      e.pmask[r*16 +: 16] = le[r] ? 16'hFFFF : 16'h0;
      if (le[r]) begin
        e.psum_s[r*20 +: 20] = sres[19:0];
        e.psum_w[r*20 +: 20] = res[19:0];
        e.prod[r*16 +: 16]   = arith ? p[15:0] : 16'h0;
        e.ovf[r]             = ov;
      end
    end
    return e;
  endfunction

  // Output monitor: samples on the falling edge, scores transfers and holds during stalls.
  initial begin : mon
    logic         stall_p;
    logic [155:0] prev;
    exp_t         e;
    stall_p = 1'b0;
    prev    = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        stall_p = 1'b0;
      end else begin
        if (stall_p) check("stall_hold", {dst_rdy, o_psum, o_prod, o_ovf, o_side}, {1'b1, prev});
        if (dst_rdy && dst_ack) begin
          check("out_expected", 192'(exp_q.size() > 0), 192'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("psum_sat",  o_psum, e.psum_s);
            check("psum_wrap", o_psum_w, e.psum_w);
            check("prod",      o_prod & e.pmask, e.prod);
            check("prod_w",    o_prod_w & e.pmask, e.prod);
            check("ovf",       o_ovf, e.ovf);
            check("ovf_w",     o_ovf_w, e.ovf);
            check("side",      {o_side, o_side_w}, {e.side, e.side});
            check("rdy_w",     dst_rdy_w, 1'b1);
            n_out++;
          end
        end
        stall_p = dst_rdy && !dst_ack;
        prev    = {o_psum, o_prod, o_ovf, o_side};
        if (src_rdy && src_ack)
          exp_q.push_back(model(i_mode, i_signed, i_lane_en, i_input, i_weight, i_psum, i_side));
      end
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic s, input logic [3:0] le,
                       input logic [31:0] inv, input logic [31:0] wv, input logic [79:0] pv,
                       input logic [7:0] sd);
    i_mode = m; i_signed = s; i_lane_en = le; i_input = inv; i_weight = wv; i_psum = pv;
    i_side = sd;
  endtask

  task automatic rand_tx();
    i_mode    = 2'($urandom_range(0, 3));
    i_signed  = 1'($urandom_range(0, 1));
    i_lane_en = 4'($urandom);
    i_input   = $urandom;
    i_weight  = $urandom;
    i_side    = 8'($urandom);
    for (int r = 0; r < 4; r++) i_psum[r*20 +: 20] = 20'($urandom);
  endtask

  // One transaction into an empty pipe, held at the output; lat counts cycles to dst_rdy.
  task automatic send_one(output int lat);
    src_rdy = 1'b1;
    cyc();
    src_rdy = 1'b0;
    lat = 1;
    while (!dst_rdy && lat < 20) begin
      cyc();
      lat++;
    end
  endtask

  task automatic ack_one();
    dst_ack = 1'b1;
    cyc();
    dst_ack = 1'b0;
  endtask

  task automatic run_stream(input int n, input bit fixed_bp);
    int sent, c, start;
    bit acc;
    sent = 0; c = 0; start = n_out;
    rand_tx();
    while ((sent < n || exp_q.size() != 0) && c < 400) begin
      dst_ack = fixed_bp ? !(c >= 3 && c < 6) : ($urandom_range(0, 3) != 0);
      src_rdy = (sent < n) && (fixed_bp || ($urandom_range(0, 4) != 0));
      @(negedge i_clk);
      acc = src_rdy && src_ack;
      cyc();
      if (acc) begin
        sent++;
        rand_tx();
      end
      c++;
    end
    src_rdy = 1'b0;
    dst_ack = 1'b0;
    check("stream_count", n_out - start, n);
    check("stream_drained", exp_q.size(), 0);
  endtask

  initial begin
    int lat;
    logic [79:0] ps;
    i_rst = 1'b1; src_rdy = 1'b0; dst_ack = 1'b0;
    drive(2'd0, 1'b0, 4'h0, '0, '0, '0, 8'h00);
    cyc(); cyc();
    check("rst_outputs", {dst_rdy, o_busy, o_psum, o_prod, o_ovf, o_side}, '0);
    check("rst_src_ack", src_ack, 1'b1);
    i_rst = 1'b0;
    cyc();

    // Unsigned MAC, largest operands
    drive(MS_MAC, 1'b0, 4'hF, {4{8'd255}}, {4{8'd255}}, {4{20'd1}}, 8'h11);
    send_one(lat);
    check("mac_u_latency", lat, NSTAGE);
    check("mac_u_psum", o_psum[19:0], 20'h0FE02);
    check("mac_u_prod", o_prod[15:0], 16'hFE01);
    check("mac_u_ovf", o_ovf, 4'h0);
    ack_one();

    // Signed MAC then MUL ignoring psum
    drive(MS_MAC, 1'b1, 4'hF, {4{8'h80}}, {4{8'd127}}, {4{20'hFFFFB}}, 8'h22);
    send_one(lat);
    check("mac_s_latency", lat, NSTAGE);
    check("mac_s_psum", o_psum[19:0], 20'hFC07B);
    check("mac_s_prod", o_prod[15:0], 16'hC080);
    ack_one();
    drive(MS_MUL, 1'b1, 4'hF, {4{8'h80}}, {4{8'd127}}, {4{20'hFFFFB}}, 8'h33);
    send_one(lat);
    check("mul_s_psum", o_psum[19:0], 20'hFC080);
    ack_one();

    // Signed saturation vs wrap
    drive(MS_MAC, 1'b1, 4'hF, {4{8'd2}}, {4{8'd3}}, {4{20'h7FFFF}}, 8'h44);
    send_one(lat);
    check("sat_psum", o_psum[19:0], 20'h7FFFF);
    check("sat_ovf", o_ovf, 4'hF);
    check("wrap_psum", o_psum_w[19:0], 20'h80005);
    check("wrap_ovf", o_ovf_w, 4'hF);
    ack_one();

    // Bypass with lanes 1 and 3 disabled
    for (int r = 0; r < 4; r++) ps[r*20 +: 20] = 20'($urandom);
    drive(MS_BYPASS, 1'b1, 4'b0101, $urandom, $urandom, ps, 8'hA5);
    send_one(lat);
    check("byp_psum", o_psum, ps & {20'h0, 20'hFFFFF, 20'h0, 20'hFFFFF});
    check("byp_side", o_side, 8'hA5);
    check("byp_ovf", o_ovf, 4'h0);
    ack_one();

    run_stream(8, 1'b1);
    run_stream(40, 1'b0);

    // Reset with two transactions in flight
    rand_tx();
    dst_ack = 1'b0;
    src_rdy = 1'b1;
    cyc(); cyc();
    src_rdy = 1'b0;
    check("pre_rst_busy", {o_busy, dst_rdy}, 2'b11);
    i_rst = 1'b1;
    #1;
    check("mid_rst_clear", {dst_rdy, o_busy, o_busy_w, o_psum}, '0);
    exp_q.delete();
    cyc();
    i_rst = 1'b0;
    dst_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("post_rst_idle", {dst_rdy, o_busy}, 2'b00);
    end
    dst_ack = 1'b0;
    rand_tx();
    send_one(lat);
    check("post_rst_latency", lat, NSTAGE);
    ack_one();
    cyc();
    check("final_idle", {o_busy, 32'(exp_q.size())}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
